// File: rtl/wb_spiflash_reader_pkg.sv
// Shared constants, FSM state encoding and helpers for the Wishbone SPI flash reader.
package wb_spiflash_reader_pkg;

   localparam logic [7:0]  OpRead = 8'h03;
   localparam logic [7:0]  OpWake = 8'hAB;

   // Bit counts per frame; LenW must hold ReadBits.
   localparam int unsigned LenW        = 7;
   localparam int unsigned WakeBits    = 8;
   localparam int unsigned CmdBits     = 8;
   localparam int unsigned AddrEndBits = 32;
   localparam int unsigned ReadBits    = 64;

   typedef enum logic [2:0] {
      StWake,
      StGap,
      StIdle,
      StCmd,
      StAddr,
      StData,
      StDone
   } state_e;

   // Flash returns b0 first; the bus word is {b3,b2,b1,b0}.
   function automatic logic [31:0] byte_swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/wb_spiflash_reader_shift.sv
// SPI mode-0 shift engine.
//  clk_i/rst_i   : clock, synchronous active-high reset
//  start_i       : load data_i (MSB first) and shift len_i bits
//  miso_i        : serial input, sampled on the cycle SCK rises
//  sck_o/mosi_o  : serial clock (idles low) and output data
//  active_o      : frame in progress (used directly as inverted chip select)
//  done_o        : one-cycle pulse after the last SCK falling edge
//  bit_cnt_o     : bits completed in the current frame
//  rx_o          : last 32 bits received, newest in bit 0
module wb_spiflash_reader_shift
   import wb_spiflash_reader_pkg::*;
#(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [LenW-1:0] len_i,
   input  logic [63:0]     data_i,
   input  logic            miso_i,
   output logic            sck_o,
   output logic            mosi_o,
   output logic            active_o,
   output logic            done_o,
   output logic [LenW-1:0] bit_cnt_o,
   output logic [31:0]     rx_o
);

   localparam int unsigned    DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

   logic            active_q, active_d;
   logic            sck_q, sck_d;
   logic            done_q, done_d;
   logic [DivW-1:0] div_q, div_d;
   logic [63:0]     sh_q, sh_d;
   logic [31:0]     rx_q, rx_d;
   logic [LenW-1:0] len_q, len_d;
   logic [LenW-1:0] cnt_q, cnt_d;

   always_comb begin
      active_d = active_q;
      sck_d    = sck_q;
      done_d   = 1'b0;
      div_d    = div_q;
      sh_d     = sh_q;
      rx_d     = rx_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      if (start_i) begin
         active_d = 1'b1;
         sck_d    = 1'b0;
         div_d    = '0;
         sh_d     = data_i;
         len_d    = len_i;
         cnt_d    = '0;
      end else if (active_q) begin
         if (div_q == DivLast) begin
            div_d = '0;
            sck_d = ~sck_q;
            if (!sck_q) begin
               rx_d = {rx_q[30:0], miso_i};
            end else begin
               // Falling edge ends the bit; next MOSI bit appears while SCK is low.
               sh_d  = {sh_q[62:0], 1'b0};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q + 1'b1 == len_q) begin
                  active_d = 1'b0;
                  done_d   = 1'b1;
               end
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         sck_q    <= 1'b0;
         done_q   <= 1'b0;
         div_q    <= '0;
         sh_q     <= '0;
         rx_q     <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
      end else begin
         active_q <= active_d;
         sck_q    <= sck_d;
         done_q   <= done_d;
         div_q    <= div_d;
         sh_q     <= sh_d;
         rx_q     <= rx_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
      end
   end

   assign sck_o     = sck_q;
   assign mosi_o    = active_q & sh_q[63];
   assign active_o  = active_q;
   assign done_o    = done_q;
   assign bit_cnt_o = cnt_q;
   assign rx_o      = rx_q;

endmodule

// File: rtl/wb_spiflash_reader.sv
// Wishbone-classic read-only slave returning 32-bit words from an SPI NOR flash (READ 0x03).
// Issues a 0xAB power-up frame after reset before serving reads. Writes are acked and dropped.
//  wb_clk_i/wb_rst_i : clock, synchronous active-high reset
//  wbs_*             : Wishbone slave port; adr[23:2] selects the word
//  spi_*             : flash pins (CSB active low, SCK idles low, MSB first)
//  busy_o            : high outside IDLE (frame or inter-frame gap in progress)
module wb_spiflash_reader
   import wb_spiflash_reader_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 1,
   parameter int unsigned CS_IDLE    = 2,
   parameter logic [23:0] FLASH_BASE = 24'h0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        spi_csb_o,
   output logic        spi_clk_o,
   output logic        spi_mosi_o,
   input  logic        spi_miso_i,
   output logic        busy_o
);

   localparam int unsigned GapW = $clog2(CS_IDLE + 1);

   state_e          state_q, state_d;
   logic            ack_q, ack_d;
   logic [31:0]     dat_q, dat_d;
   logic [GapW-1:0] gap_q, gap_d;

   logic            eng_start;
   logic [LenW-1:0] eng_len;
   logic [63:0]     eng_data;
   logic            eng_active, eng_done;
   logic [LenW-1:0] eng_bit_cnt;
   logic [31:0]     eng_rx;

   logic            req;
   logic [23:0]     req_addr;

   logic unused_inputs;
   assign unused_inputs = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i[31:24], wbs_adr_i[1:0]};

   // ack_q gates the request so the strobe still high during the ack cycle is not re-served.
   assign req      = wbs_stb_i & wbs_cyc_i & ~ack_q;
   assign req_addr = FLASH_BASE + {wbs_adr_i[23:2], 2'b00};

   always_comb begin
      state_d   = state_q;
      ack_d     = 1'b0;
      dat_d     = dat_q;
      gap_d     = gap_q;
      eng_start = 1'b0;
      eng_len   = LenW'(ReadBits);
      // The engine's shift register holds the latched address for the whole frame.
      eng_data  = {OpRead, req_addr, 32'h0};
      unique case (state_q)
         StWake: begin
            eng_len  = LenW'(WakeBits);
            eng_data = {OpWake, 56'h0};
            if (eng_done) begin
               state_d = StGap;
               gap_d   = GapW'(CS_IDLE - 1);
            end else if (!eng_active) begin
               eng_start = 1'b1;
            end
         end
         StGap: begin
            if (gap_q == '0) state_d = StIdle;
            else             gap_d   = gap_q - 1'b1;
         end
         StIdle: begin
            if (req) begin
               if (wbs_we_i) begin
                  ack_d = 1'b1;
               end else begin
                  eng_start = 1'b1;
                  state_d   = StCmd;
               end
            end
         end
         StCmd:  if (eng_bit_cnt >= LenW'(CmdBits)) state_d = StAddr;
         StAddr: if (eng_bit_cnt >= LenW'(AddrEndBits)) state_d = StData;
         StData: if (eng_done) state_d = StDone;
         StDone: begin
            ack_d   = 1'b1;
            dat_d   = byte_swap32(eng_rx);
            state_d = StGap;
            gap_d   = GapW'(CS_IDLE - 1);
         end
         default: state_d = StWake;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= StWake;
         ack_q   <= 1'b0;
         dat_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         gap_q   <= gap_d;
      end
   end

   wb_spiflash_reader_shift #(
      .CLK_DIV (CLK_DIV)
   ) u_shift (
      .clk_i     (wb_clk_i),
      .rst_i     (wb_rst_i),
      .start_i   (eng_start),
      .len_i     (eng_len),
      .data_i    (eng_data),
      .miso_i    (spi_miso_i),
      .sck_o     (spi_clk_o),
      .mosi_o    (spi_mosi_o),
      .active_o  (eng_active),
      .done_o    (eng_done),
      .bit_cnt_o (eng_bit_cnt),
      .rx_o      (eng_rx)
   );

   assign spi_csb_o = ~eng_active;
   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_wb_spiflash_reader.sv
// Bench for wb_spiflash_reader: instance 0 uses CLK_DIV=1, instance 1 uses CLK_DIV=3.
// A small mode-0 flash model per instance serves the image 0x000=DE AD BE EF, 0x100=01 02 03 04.
module tb_wb_spiflash_reader;

   logic        clk = 1'b0;
   logic [1:0]  rst = 2'b11;
   logic [1:0]  stb = 2'b00;
   logic [1:0]  cyc = 2'b00;
   logic        we  = 1'b0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] adr = '0;
   logic [31:0] dat_w = '0;
   logic [1:0]  ack, csb, sck, mosi, busy;
   logic [1:0]  miso = 2'b00;
   logic [31:0] dat_o [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      wb_spiflash_reader #(
         .CLK_DIV    ((g == 0) ? 1 : 3),
         .CS_IDLE    (2),
         .FLASH_BASE (24'h0)
      ) u_dut (
         .wb_clk_i   (clk),
         .wb_rst_i   (rst[g]),
         .wbs_stb_i  (stb[g]),
         .wbs_cyc_i  (cyc[g]),
         .wbs_we_i   (we),
         .wbs_sel_i  (sel),
         .wbs_adr_i  (adr),
         .wbs_dat_i  (dat_w),
         .wbs_ack_o  (ack[g]),
         .wbs_dat_o  (dat_o[g]),
         .spi_csb_o  (csb[g]),
         .spi_clk_o  (sck[g]),
         .spi_mosi_o (mosi[g]),
         .spi_miso_i (miso[g]),
         .busy_o     (busy[g])
      );
   end

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] sb_q [$];

   function automatic logic [7:0] fbyte(input logic [23:0] a);
      case (a)
         24'h000: return 8'hDE;
         24'h001: return 8'hAD;
         24'h002: return 8'hBE;
         24'h003: return 8'hEF;
         24'h100: return 8'h01;
         24'h101: return 8'h02;
         24'h102: return 8'h03;
         24'h103: return 8'h04;
         default: return 8'hFF;
      endcase
   endfunction

   // Flash model and frame monitor, sampled on the falling clock edge.
   int          cyc_n = 0;
   int          bitc [2]       = '{0, 0};
   int          frame_cnt [2]  = '{0, 0};
   int          frame_bits [2] = '{0, 0};
   int          hi_run [2]     = '{0, 0};
   int          min_gap [2]    = '{1000, 1000};
   int          sck_per [2]    = '{0, 0};
   int          last_rise [2]  = '{-1, -1};
   int          ack_cnt [2]    = '{0, 0};
   logic [31:0] shin [2]       = '{32'h0, 32'h0};
   logic [31:0] frame_word [2] = '{32'h0, 32'h0};
   logic [7:0]  cmd [2]        = '{8'h0, 8'h0};
   logic [23:0] faddr [2]      = '{24'h0, 24'h0};
   logic [1:0]  prev_csb = 2'b11;
   logic [1:0]  prev_sck = 2'b00;

   always @(negedge clk) begin : mon
      int k;
      logic [7:0] b;
      cyc_n++;
      for (int i = 0; i < 2; i++) begin
         if (prev_csb[i] && !csb[i]) begin
            bitc[i] = 0;
            shin[i] = '0;
            cmd[i] = '0;
            last_rise[i] = -1;
            if (frame_cnt[i] > 0 && hi_run[i] < min_gap[i]) min_gap[i] = hi_run[i];
         end else if (!prev_csb[i] && csb[i]) begin
            frame_cnt[i]++;
            frame_bits[i] = bitc[i];
            frame_word[i] = shin[i];
            hi_run[i] = 0;
         end
         if (csb[i]) begin
            hi_run[i]++;
         end else begin
            if (!prev_sck[i] && sck[i]) begin
               if (bitc[i] < 32) shin[i] = {shin[i][30:0], mosi[i]};
               bitc[i]++;
               if (bitc[i] == 8) cmd[i] = shin[i][7:0];
               if (bitc[i] == 32) faddr[i] = shin[i][23:0];
               if (last_rise[i] >= 0) sck_per[i] = cyc_n - last_rise[i];
               last_rise[i] = cyc_n;
            end
            if (prev_sck[i] && !sck[i] && cmd[i] == 8'h03 && bitc[i] >= 32) begin
               k = bitc[i] - 32;
               b = fbyte(faddr[i] + 24'(k / 8));
               miso[i] = b[7 - (k % 8)];
            end
         end
         if (ack[i]) ack_cnt[i]++;
         prev_csb[i] = csb[i];
         prev_sck[i] = sck[i];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input int i);
      int n = 0;
      while (busy[i] && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", {63'h0, busy[i]}, 64'h0);
   endtask

   task automatic wait_frames(input int i, input int target);
      int n = 0;
      while (frame_cnt[i] < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("frame_seen", {63'h0, frame_cnt[i] >= target}, 64'h1);
   endtask

   // exp_lat < 0 skips the latency check (request already pending).
   task automatic wb_read(input int i, input logic [31:0] a, input logic [31:0] exp,
                          input int exp_lat, input bit hold);
      int lat = 0;
      logic [31:0] e;
      adr = a;
      we = 1'b0;
      stb[i] = 1'b1;
      cyc[i] = 1'b1;
      sb_q.push_back(exp);
      do begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end while (!ack[i] && lat < 3000);
      check("rd_ack_seen", {63'h0, ack[i]}, 64'h1);
      if (exp_lat >= 0) check("rd_latency", 64'(lat - 1), 64'(exp_lat));
      e = sb_q.pop_front();
      check("rd_data", {32'h0, dat_o[i]}, {32'h0, e});
      if (!hold) begin
         stb[i] = 1'b0;
         cyc[i] = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check("ack_one_cycle", {63'h0, ack[i]}, 64'h0);
   endtask

   initial begin
      int fc;
      int ac;
      int n;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_csb", {63'h0, csb[0]}, 64'h1);
      check("rst_sck", {63'h0, sck[0]}, 64'h0);
      check("rst_mosi", {63'h0, mosi[0]}, 64'h0);
      check("rst_ack", {63'h0, ack[0]}, 64'h0);
      check("rst_dat", {32'h0, dat_o[0]}, 64'h0);
      check("rst_busy", {62'h0, busy}, 64'h3);
      rst = 2'b00;

      // Wake frame on both instances
      wait_frames(0, 1);
      wait_frames(1, 1);
      check("wake_bits0", 64'(frame_bits[0]), 64'd8);
      check("wake_op0", {32'h0, frame_word[0]}, 64'hAB);
      check("wake_bits1", 64'(frame_bits[1]), 64'd8);
      check("wake_op1", {32'h0, frame_word[1]}, 64'hAB);
      wait_idle(0);
      wait_idle(1);

      // Read 0x0, CLK_DIV=1
      wb_read(0, 32'h0, 32'hEFBEADDE, 128 * 1 + 2, 1'b0);
      check("rd0_mosi", {32'h0, frame_word[0]}, 64'h03000000);
      check("rd0_bits", 64'(frame_bits[0]), 64'd64);
      check("wake_gap0", {63'h0, min_gap[0] >= 2}, 64'h1);

      // Read 0x100, CLK_DIV=3
      wb_read(1, 32'h100, 32'h04030201, 128 * 3 + 2, 1'b0);
      check("rd1_mosi", {32'h0, frame_word[1]}, 64'h03000100);
      check("rd1_sck_period", 64'(sck_per[1]), 64'd6);

      // Write: immediate ack, no SPI frame, read data untouched
      wait_idle(0);
      fc = frame_cnt[0];
      adr = 32'h4;
      dat_w = 32'h12345678;
      we = 1'b1;
      stb[0] = 1'b1;
      cyc[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("wr_ack_next", {63'h0, ack[0]}, 64'h1);
      stb[0] = 1'b0;
      cyc[0] = 1'b0;
      we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("wr_ack_one_cycle", {63'h0, ack[0]}, 64'h0);
      check("wr_csb_high", {63'h0, csb[0]}, 64'h1);
      check("wr_no_frame", 64'(frame_cnt[0]), 64'(fc));
      check("wr_dat_kept", {32'h0, dat_o[0]}, 64'hEFBEADDE);

      // Back-to-back reads with strobe held
      wait_idle(0);
      fc = frame_cnt[0];
      ac = ack_cnt[0];
      wb_read(0, 32'h100, 32'h04030201, 128 + 2, 1'b1);
      wb_read(0, 32'h100, 32'h04030201, -1, 1'b0);
      check("b2b_frames", 64'(frame_cnt[0] - fc), 64'd2);
      check("b2b_acks", 64'(ack_cnt[0] - ac), 64'd2);
      check("b2b_gap", {63'h0, min_gap[0] >= 2}, 64'h1);

      // Reset during the address phase
      wait_idle(0);
      fc = frame_cnt[0];
      ac = ack_cnt[0];
      adr = 32'h0;
      stb[0] = 1'b1;
      cyc[0] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(csb[0] == 1'b0 && bitc[0] >= 16 && bitc[0] < 32) && n < 500);
      check("rst_in_addr_phase", {63'h0, csb[0] == 1'b0 && bitc[0] >= 16 && bitc[0] < 32},
            64'h1);
      rst[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_csb", {63'h0, csb[0]}, 64'h1);
      check("abort_no_ack", {63'h0, ack[0]}, 64'h0);
      stb[0] = 1'b0;
      cyc[0] = 1'b0;
      rst[0] = 1'b0;
      wait_frames(0, fc + 2);
      check("rewake_bits", 64'(frame_bits[0]), 64'd8);
      check("rewake_op", {32'h0, frame_word[0]}, 64'hAB);
      check("abort_acks", 64'(ack_cnt[0] - ac), 64'd0);
      wait_idle(0);
      wb_read(0, 32'h0, 32'hEFBEADDE, 128 + 2, 1'b0);
      check("final_gap1", {63'h0, min_gap[1] >= 2}, 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
